chart_sequencer: RTL and testbench

Step-chart controller that sequences the arrow datapath. It holds a small chart memory of timed steps, each with a lane mask and a frame delay. It waits the programmed number of frame ticks, then issues one-cycle launch pulses to the arrow movers. It also accumulates score and combo from the movers' judge outputs. It sits between the frame timing generator, the arrow movement blocks and the score display.

---
 rtl/chart_pkg.sv | 44 ++++
 rtl/chart_sequencer_if.sv | 45 ++++
 rtl/chart_ram.sv | 29 ++
 rtl/chart_sequencer.sv | 159 +++++++++++++++
 tb/tb_chart_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/chart_pkg.sv
// Shared types and constants for the step-chart sequencer.
// Provides the FSM state enum, the chart entry layout and judge point values.
package chart_pkg;

    localparam int LANES_D       = 4;
    localparam int CHART_DEPTH_D = 32;
    localparam int DELAY_W_D     = 8;
    localparam int SCORE_W_D     = 16;
    localparam int COMBO_W_D     = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        FIRE,
        DONE
    } state_t;

    // Chart entry for the default geometry: {end, lane_mask, delay}.
    typedef struct packed {
        logic                 last;
        logic [LANES_D-1:0]   lane_mask;
        logic [DELAY_W_D-1:0] delay;
    } entry_t;

    localparam logic [2:0] PTS_MARVELOUS = 3'd4;
    localparam logic [2:0] PTS_PERFECT   = 3'd3;
    localparam logic [2:0] PTS_GREAT     = 3'd2;
    localparam logic [2:0] PTS_GOOD      = 3'd1;

    // judge = {marvelous, perfect, great, good}; highest set bit wins.
    function automatic logic [2:0] judge_points(input logic [3:0] judge);
        logic [2:0] pts;
        priority case (1'b1)
            judge[3]: pts = PTS_MARVELOUS;
            judge[2]: pts = PTS_PERFECT;
            judge[1]: pts = PTS_GREAT;
            judge[0]: pts = PTS_GOOD;
            default:  pts = 3'd0;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/chart_sequencer_if.sv
// Bundle of control, chart-write, judge and status signals of the sequencer.
// slave: the sequencer side; master: the driving environment side.
interface chart_sequencer_if #(
    parameter int LANES       = 4,
    parameter int CHART_DEPTH = 32,
    parameter int DELAY_W     = 8,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8
);
    localparam int AW = $clog2(CHART_DEPTH);
    localparam int EW = 1 + LANES + DELAY_W;

    logic               frame_i;
    logic               start_i;
    logic               abort_i;
    logic               pause_i;
    logic               wr_en_i;
    logic [AW-1:0]      wr_addr_i;
    logic [EW-1:0]      wr_data_i;
    logic [3:0]         judge_i;
    logic               miss_i;
    logic [LANES-1:0]   launch_o;
    logic               busy_o;
    logic               done_o;
    logic [AW-1:0]      step_idx_o;
    logic [SCORE_W-1:0] score_o;
    logic [COMBO_W-1:0] combo_o;

    modport master (
        output frame_i, start_i, abort_i, pause_i,
        output wr_en_i, wr_addr_i, wr_data_i,
        output judge_i, miss_i,
        input  launch_o, busy_o, done_o,
        input  step_idx_o, score_o, combo_o
    );

    modport slave (
        input  frame_i, start_i, abort_i, pause_i,
        input  wr_en_i, wr_addr_i, wr_data_i,
        input  judge_i, miss_i,
        output launch_o, busy_o, done_o,
        output step_idx_o, score_o, combo_o
    );

endinterface

// File: rtl/chart_ram.sv
// Chart memory: one write port, registered synchronous read port.
// Ports: clk, we/waddr/wdata (write), re/raddr (read request), rdata.
module chart_ram #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 13,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/chart_sequencer.sv
// Step-chart controller: fetches timed entries, waits frame ticks, fires
// lane launch pulses, and accumulates score/combo. Ports: clk_i, reset_ni, bus.
module chart_sequencer
    import chart_pkg::*;
#(
    parameter int LANES       = LANES_D,
    parameter int CHART_DEPTH = CHART_DEPTH_D,
    parameter int DELAY_W     = DELAY_W_D,
    parameter int SCORE_W     = SCORE_W_D,
    parameter int COMBO_W     = COMBO_W_D
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    chart_sequencer_if.slave bus
);

    localparam int AW = $clog2(CHART_DEPTH);
    localparam int EW = 1 + LANES + DELAY_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(CHART_DEPTH - 1);

    state_t             state;
    logic [AW-1:0]      ptr;
    logic [DELAY_W-1:0] delay_cnt;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic               busy;
    logic               done;

    logic [EW-1:0]      rd_data;
    logic               ent_last;
    logic [LANES-1:0]   ent_mask;
    logic [DELAY_W-1:0] ent_delay;

    assign ent_last  = rd_data[EW-1];
    assign ent_mask  = rd_data[DELAY_W +: LANES];
    assign ent_delay = rd_data[DELAY_W-1:0];

    chart_ram #(
        .DEPTH (CHART_DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk_i),
        .we    (bus.wr_en_i & ~busy),
        .waddr (bus.wr_addr_i),
        .wdata (bus.wr_data_i),
        .re    (state == FETCH),
        .raddr (ptr),
        .rdata (rd_data)
    );

    // Score/combo next values, applied in every non-idle state.
    logic               hit;
    logic [2:0]         pts;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_nxt;
    logic [COMBO_W-1:0] combo_nxt;

    assign hit       = |bus.judge_i;
    assign pts       = judge_points(bus.judge_i);
    assign score_sum = {1'b0, score} + {{(SCORE_W - 2){1'b0}}, pts};
    assign score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    always_comb begin
        combo_nxt = combo;
        if (bus.miss_i) begin
            // A hit on the same cycle as a miss starts a fresh combo.
            combo_nxt = hit ? COMBO_W'(1) : '0;
        end else if (hit && combo != '1) begin
            combo_nxt = combo + COMBO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            ptr       <= '0;
            delay_cnt <= '0;
            score     <= '0;
            combo     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (state != IDLE) begin
                score <= score_nxt;
                combo <= combo_nxt;
            end
            unique case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        ptr   <= '0;
                        score <= '0;
                        combo <= '0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.abort_i) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        delay_cnt <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.abort_i) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (delay_cnt == ent_delay) begin
                        state <= FIRE;
                    end else if (bus.frame_i && !bus.pause_i) begin
                        delay_cnt <= delay_cnt + DELAY_W'(1);
                    end
                end
                FIRE: begin
                    if (bus.abort_i) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (ent_last || ptr == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        ptr   <= ptr + AW'(1);
                        state <= FETCH;
                    end
                end
                DONE: begin
                    if (bus.abort_i) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else if (bus.start_i) begin
                        ptr   <= '0;
                        score <= '0;
                        combo <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= FETCH;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Launch is decoded so the pulse lands in the FIRE cycle itself.
    assign bus.launch_o   = (state == FIRE && !bus.abort_i) ? ent_mask : '0;
    assign bus.busy_o     = busy;
    assign bus.done_o     = done;
    assign bus.step_idx_o = ptr;
    assign bus.score_o    = score;
    assign bus.combo_o    = combo;

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed self-checking bench for chart_sequencer.
// Drives the interface master side; compares against hand-computed values.
module tb_chart_sequencer;
    import chart_pkg::*;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    chart_sequencer_if #(
        .LANES(4), .CHART_DEPTH(32), .DELAY_W(8), .SCORE_W(16), .COMBO_W(8)
    ) bus ();

    chart_sequencer #(
        .LANES(4), .CHART_DEPTH(32), .DELAY_W(8), .SCORE_W(16), .COMBO_W(8)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr(input int a, input logic last, input logic [3:0] m,
                      input logic [7:0] d);
        entry_t e;
        e.last = last;
        e.lane_mask = m;
        e.delay = d;
        bus.wr_en_i = 1'b1;
        bus.wr_addr_i = 5'(a);
        bus.wr_data_i = e;
        tick();
        bus.wr_en_i = 1'b0;
    endtask

    // One frame pulse (optionally paused) followed by one idle cycle.
    task automatic pulse_frame(input logic p);
        bus.frame_i = 1'b1;
        bus.pause_i = p;
        tick();
        bus.frame_i = 1'b0;
        bus.pause_i = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] jv [6];
        logic [3:0] ms [6];
        int es [6];
        int ec [6];
        int fires;
        int bad_gap;
        int bad_mask;
        int last_cyc;
        logic [3:0] exp_m;
        logic [3:0] seen;

        bus.frame_i = 0; bus.start_i = 0; bus.abort_i = 0; bus.pause_i = 0;
        bus.wr_en_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        bus.judge_i = '0; bus.miss_i = 0;

        // Reset state
        #12;
        chk("rst_launch", 32'(bus.launch_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_step", 32'(bus.step_idx_o), 0);
        chk("rst_score", 32'(bus.score_o), 0);
        chk("rst_combo", 32'(bus.combo_o), 0);
        reset_ni = 1'b1;
        tick();

        // Basic three-entry chart
        wr(0, 0, 4'b0001, 2);
        wr(1, 0, 4'b0110, 0);
        wr(2, 1, 4'b1000, 1);
        bus.start_i = 1; tick(); bus.start_i = 0;
        chk("t1_busy", 32'(bus.busy_o), 1);
        tick();
        pulse_frame(0);
        chk("t1_wait1", 32'(bus.launch_o), 0);
        pulse_frame(0);
        chk("t1_l0", 32'(bus.launch_o), 4'b0001);
        tick();
        chk("t1_gap", 32'(bus.launch_o), 0);
        tick(); tick();
        chk("t1_l1", 32'(bus.launch_o), 4'b0110);
        tick(); tick();
        pulse_frame(0);
        chk("t1_l2", 32'(bus.launch_o), 4'b1000);
        tick();
        chk("t1_done", 32'(bus.done_o), 1);
        chk("t1_step", 32'(bus.step_idx_o), 2);
        chk("t1_busy0", 32'(bus.busy_o), 0);

        // Pause gating: delay 3, two of five frames paused
        wr(0, 1, 4'b0101, 3);
        bus.start_i = 1; tick(); bus.start_i = 0;
        tick();
        pulse_frame(0);
        pulse_frame(1);
        pulse_frame(0);
        pulse_frame(1);
        chk("t2_pre", 32'(bus.launch_o), 0);
        chk("t2_busy", 32'(bus.busy_o), 1);
        pulse_frame(0);
        chk("t2_fire", 32'(bus.launch_o), 4'b0101);

        // Full 32-entry chart, no end flag, delay 0
        tick();
        for (int i = 0; i < 32; i++) wr(i, 0, 4'(1 << (i % 4)), 0);
        bus.start_i = 1; tick(); bus.start_i = 0;
        fires = 0; bad_gap = 0; bad_mask = 0; last_cyc = -1;
        for (int c = 0; c < 200 && !bus.done_o; c++) begin
            tick();
            if (bus.launch_o != 0) begin
                exp_m = 4'(1 << (fires % 4));
                if (bus.launch_o != exp_m) bad_mask++;
                if (last_cyc >= 0 && c - last_cyc != 3) bad_gap++;
                last_cyc = c;
                fires++;
            end
        end
        chk("t3_fires", 32'(fires), 32);
        chk("t3_gap", 32'(bad_gap), 0);
        chk("t3_mask", 32'(bad_mask), 0);
        chk("t3_done", 32'(bus.done_o), 1);
        chk("t3_step", 32'(bus.step_idx_o), 31);

        // Scoring in DONE
        jv = '{4'b1000, 4'b0100, 4'b1111, 4'b0001, 4'b0000, 4'b0010};
        ms = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        es = '{4, 7, 11, 12, 12, 14};
        ec = '{1, 2, 3, 4, 0, 1};
        for (int i = 0; i < 6; i++) begin
            bus.judge_i = jv[i];
            bus.miss_i = ms[i][0];
            tick();
            bus.judge_i = '0;
            bus.miss_i = 0;
            chk($sformatf("t4_score%0d", i), 32'(bus.score_o), 32'(es[i]));
            chk($sformatf("t4_combo%0d", i), 32'(bus.combo_o), 32'(ec[i]));
        end
        bus.judge_i = 4'b0001; bus.miss_i = 1; tick();
        bus.judge_i = '0; bus.miss_i = 0;
        chk("t4_mj_score", 32'(bus.score_o), 15);
        chk("t4_mj_combo", 32'(bus.combo_o), 1);

        // Abort during WAIT of entry 1
        wr(0, 0, 4'b0011, 0);
        wr(1, 0, 4'b1100, 5);
        wr(2, 1, 4'b1111, 0);
        bus.start_i = 1; tick(); bus.start_i = 0;
        chk("t5_clr", 32'(bus.score_o), 0);
        bus.judge_i = 4'b0100; tick(); bus.judge_i = '0;
        tick();
        chk("t5_l0", 32'(bus.launch_o), 4'b0011);
        tick(); tick();
        bus.abort_i = 1; tick(); bus.abort_i = 0;
        chk("t5_busy", 32'(bus.busy_o), 0);
        chk("t5_done", 32'(bus.done_o), 0);
        chk("t5_score", 32'(bus.score_o), 3);
        chk("t5_combo", 32'(bus.combo_o), 1);
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            bus.frame_i = 1; tick(); bus.frame_i = 0;
            seen |= bus.launch_o;
            tick();
            seen |= bus.launch_o;
        end
        chk("t5_nolaunch", 32'(seen), 0);
        chk("t5_idle", 32'(bus.busy_o), 0);

        // Write in IDLE accepted, write while busy ignored
        wr(0, 1, 4'b1010, 0);
        bus.start_i = 1; tick(); bus.start_i = 0;
        wr(0, 1, 4'b0101, 0);
        tick();
        chk("t5_rb1", 32'(bus.launch_o), 4'b1010);
        tick();
        chk("t5_rb_done", 32'(bus.done_o), 1);
        bus.start_i = 1; tick(); bus.start_i = 0;
        tick(); tick();
        chk("t5_rb2", 32'(bus.launch_o), 4'b1010);
        tick();

        // Asynchronous reset mid-WAIT
        wr(0, 0, 4'b0011, 0);
        bus.start_i = 1; tick(); bus.start_i = 0;
        bus.judge_i = 4'b1000; tick(); bus.judge_i = '0;
        tick(); tick(); tick();
        chk("t6_pre_step", 32'(bus.step_idx_o), 1);
        chk("t6_pre_score", 32'(bus.score_o), 4);
        #3 reset_ni = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.busy_o), 0);
        chk("t6_done", 32'(bus.done_o), 0);
        chk("t6_step", 32'(bus.step_idx_o), 0);
        chk("t6_score", 32'(bus.score_o), 0);
        chk("t6_combo", 32'(bus.combo_o), 0);
        chk("t6_launch", 32'(bus.launch_o), 0);
        @(posedge clk);
        #2 reset_ni = 1'b1;
        tick();
        pulse_frame(0);
        pulse_frame(0);
        pulse_frame(0);
        chk("t6_idle_busy", 32'(bus.busy_o), 0);
        chk("t6_idle_launch", 32'(bus.launch_o), 0);
        bus.start_i = 1; tick(); bus.start_i = 0;
        chk("t6_restart", 32'(bus.busy_o), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
